// File: rtl/e_rref_hash_feeder_pkg.sv
// Shared definitions for the E_rref hash feeder: row geometry macros,
// derived stream/word sizes and the feeder FSM encoding.
// `M and `R may be overridden on the command line before this file is read.

`ifndef M
`define M 83
`endif
`ifndef R
`define R 7
`endif
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif

package e_rref_hash_feeder_pkg;

  localparam int M          = `M;                         // row width in bits
  localparam int R          = `R;                         // number of rows
  localparam int W          = 64;                         // absorb word (Keccak lane)
  localparam int RD_LAT     = 3;                          // address-to-data latency
  localparam int FIFO_DEPTH = RD_LAT + 1;

  localparam int TOTAL_BITS = R * M;
  localparam int NWORDS     = (TOTAL_BITS + W - 1) / W;
  localparam int LAST_NBITS = ((TOTAL_BITS % W) == 0) ? W : (TOTAL_BITS % W);

  localparam int AW    = `CLOG2(R);                       // row address width
  localparam int NBW   = `CLOG2(W + 1);                   // kc_nbits width
  localparam int ACC_W = W + M;                           // shift accumulator width
  localparam int ACW   = `CLOG2(ACC_W + 1);               // accumulator fill count
  localparam int RCW   = `CLOG2(R + 1);                   // row counters
  localparam int FCW   = `CLOG2(FIFO_DEPTH + 1);          // FIFO / in-flight counts

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/e_rref_hash_feeder_skid_fifo.sv
// feeder_skid_fifo: small circular buffer that catches rows returning from
// the read pipeline. Push and pop in the same cycle leave the count unchanged.
// clr empties the buffer synchronously at the start of a new hash.

module feeder_skid_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 83
) (
  input  logic                       clk,
  input  logic                       rst_b,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
  assign dout    = mem[rd_ptr];

  // Storage write; contents need no reset because count guards every read.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/e_rref_hash_feeder.sv
// e_rref_hash_feeder: on sha3_start, reads the R rows of E_rref (addresses
// 0..R-1), packs them LSB-first into W-bit absorb words for the Keccak core,
// then waits for kc_done and pulses sha3_finish. Never writes E_rref.
// Optional build macro FEEDER_LEN_PREFIX_EN: emit the message length R*M as
// an extra leading absorb word (kc_nbits=W) ahead of the row data.
//
// Absorb handshake: a word transfers on a rising edge where kc_valid and
// kc_ready are both 1; while kc_valid is 1 and kc_ready is 0, kc_data,
// kc_nbits and kc_last hold their values and kc_valid stays 1.

module e_rref_hash_feeder
  import e_rref_hash_feeder_pkg::*;
(
  input  logic           clk,
  input  logic           rst_b,
  input  logic           sha3_start,
  output logic           sha3_finish,
  output logic [AW-1:0]  sha3_mem_addr,
  output logic           sha3_mem_rw,
  input  logic [M-1:0]   sha3_mem_din,
  output logic           kc_start,
  output logic [W-1:0]   kc_data,
  output logic           kc_valid,
  output logic           kc_last,
  output logic [NBW-1:0] kc_nbits,
  input  logic           kc_ready,
  input  logic           kc_done,
  output state_t         dbg_state
);

`ifdef FEEDER_LEN_PREFIX_EN
  localparam int NWORDS_OUT = NWORDS + 1;
`else
  localparam int NWORDS_OUT = NWORDS;
`endif
  localparam int WCW = $clog2(NWORDS_OUT + 1);

  state_t           state, state_nxt;
  logic             start_acc, hs, acc_hs, issue, pop, push;
  logic             all_packed, last_word, word_ready;
  logic [RD_LAT:0]  lat_pipe;        // one bit per outstanding read, by age
  logic [FCW-1:0]   inflight, fifo_count;
  logic [FCW:0]     occupancy;
  logic [M-1:0]     fifo_dout;
  logic [RCW-1:0]   issue_cnt, rows_packed;
  logic [ACC_W-1:0] acc;             // bits above acc_cnt are always zero
  logic [ACW-1:0]   acc_cnt;
  logic [WCW-1:0]   words_sent;
  logic             prefix_pending;

  assign start_acc   = (state == ST_IDLE) && sha3_start;
  assign sha3_mem_rw = 1'b0;
  assign dbg_state   = state;
  assign push        = lat_pipe[RD_LAT];
  assign all_packed  = (rows_packed == RCW'(R));
  assign last_word   = (words_sent == WCW'(NWORDS_OUT - 1));
  assign occupancy   = {1'b0, inflight} + {1'b0, fifo_count};
  assign issue       = (state == ST_FETCH) && (issue_cnt < RCW'(R)) &&
                       (occupancy < (FCW+1)'(FIFO_DEPTH));
  assign pop         = (state == ST_FETCH) && (fifo_count != '0) && (acc_cnt < ACW'(W));
  assign word_ready  = (acc_cnt >= ACW'(W)) || (all_packed && (acc_cnt != '0));
  assign hs          = kc_valid && kc_ready;
  assign acc_hs      = hs && !prefix_pending;

  // Count reads still travelling through the memory latency.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LAT; i++) inflight = inflight + FCW'(lat_pipe[i]);
  end

  feeder_skid_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (M)
  ) u_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .clr   (start_acc),
    .push  (push),
    .din   (sha3_mem_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: a new start is only accepted from IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (sha3_start)    state_nxt = ST_FETCH;
      ST_FETCH: if (hs && kc_last) state_nxt = ST_WAIT;
      ST_WAIT:  if (kc_done)       state_nxt = ST_IDLE;
      default:                     state_nxt = ST_IDLE;
    endcase
  end

  // Absorb word presentation; driven purely from registered state so it holds under stall.
  always_comb begin
    kc_valid = 1'b0;
    kc_data  = '0;
    kc_nbits = '0;
    kc_last  = 1'b0;
    if (state == ST_FETCH) begin
      if (prefix_pending) begin
        kc_valid = 1'b1;
        kc_data  = W'(TOTAL_BITS);
        kc_nbits = NBW'(W);
        kc_last  = last_word;
      end else if (word_ready) begin
        kc_valid = 1'b1;
        kc_data  = acc[W-1:0];
        kc_nbits = last_word ? NBW'(LAST_NBITS) : NBW'(W);
        kc_last  = last_word;
      end
    end
  end

  // One-cycle pulses: core clear on entry to FETCH, finish after kc_done in WAIT.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      kc_start    <= 1'b0;
      sha3_finish <= 1'b0;
    end else begin
      kc_start    <= start_acc;
      sha3_finish <= (state == ST_WAIT) && kc_done;
    end
  end

  // Read issue: ascending addresses, address register holds when idle.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      issue_cnt     <= '0;
      sha3_mem_addr <= '0;
      lat_pipe      <= '0;
    end else begin
      lat_pipe <= {lat_pipe[RD_LAT-1:0], issue};
      if (start_acc) begin
        issue_cnt <= '0;
      end else if (issue) begin
        sha3_mem_addr <= issue_cnt[AW-1:0];
        issue_cnt     <= issue_cnt + 1'b1;
      end
    end
  end

  // Packer: append a row at the current fill level, or drain one word on handshake.
  // The two never coincide: a pop needs fewer than W bits, a data word needs W or
  // a final residue with every row already popped.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      acc         <= '0;
      acc_cnt     <= '0;
      rows_packed <= '0;
      words_sent  <= '0;
    end else if (start_acc) begin
      acc         <= '0;
      acc_cnt     <= '0;
      rows_packed <= '0;
      words_sent  <= '0;
    end else begin
      if (pop) begin
        acc         <= acc | (ACC_W'(fifo_dout) << acc_cnt);
        acc_cnt     <= acc_cnt + ACW'(M);
        rows_packed <= rows_packed + 1'b1;
      end else if (acc_hs) begin
        acc     <= acc >> W;
        acc_cnt <= acc_cnt - ACW'(kc_nbits);
      end
      if (hs) words_sent <= words_sent + 1'b1;
    end
  end

`ifdef FEEDER_LEN_PREFIX_EN
  // Length word goes out first; cleared by its own handshake.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b)         prefix_pending <= 1'b0;
    else if (start_acc) prefix_pending <= 1'b1;
    else if (hs)        prefix_pending <= 1'b0;
  end
`else
  assign prefix_pending = 1'b0;
`endif

endmodule
